// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader: walks one register-file read port and streams
// every register out as an (index, value) beat on a valid/ready port.
module regfile_dump_reader #(
   parameter int NUM_REGS = 32,
   parameter int ADDR_W   = 5,
   parameter int DATA_W   = 32,
   parameter bit SKIP_X0  = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   output logic [ADDR_W-1:0] rf_addr,
   input  logic [DATA_W-1:0] rf_data,
   output logic              dout_valid,
   input  logic              dout_ready,
   output logic [ADDR_W-1:0] dout_addr,
   output logic [DATA_W-1:0] dout_data,
   output logic              dout_last,
   output logic              busy,
   output logic              done
);

   typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} state_t;

   localparam logic [ADDR_W-1:0] FIRST_IDX =
      SKIP_X0 ? ADDR_W'(1) : '0;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              valid_q, valid_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              last_q, last_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      last_d  = last_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               idx_d   = FIRST_IDX;
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (abort) begin
               idx_d   = '0;
               state_d = IDLE;
            end else begin
               data_d  = rf_data;
               addr_d  = idx_q;
               last_d  = (idx_q == LAST_IDX);
               valid_d = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            // valid is always high here, so ready alone is the handshake
            if (abort) begin
               valid_d = 1'b0;
               idx_d   = '0;
               state_d = IDLE;
            end else if (dout_ready) begin
               valid_d = 1'b0;
               if (last_q) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = FETCH;
               end
            end
         end
         DONE: begin
            idx_d   = '0;
            state_d = IDLE;
         end
         default: begin
            idx_d   = '0;
            state_d = IDLE;
         end
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         last_q  <= last_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // idx returns to zero whenever the walk ends, so IDLE drives address 0
   assign rf_addr    = idx_q;
   assign dout_valid = valid_q;
   assign dout_addr  = addr_q;
   assign dout_data  = data_q;
   assign dout_last  = last_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule
